// File: rtl/ps2_pkg.sv
// Shared PS/2 key event definitions.
// Prefix bytes, event layout and parser states.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int EVT_W       = 10;
  localparam int EVT_CODE_LO = 0;
  localparam int EVT_BRK_BIT = 8;
  localparam int EVT_EXT_BIT = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_e;

  // Keyboard status/ack bytes that never start a key event.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hEE) || (b == 8'hAA);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
// Head word visible the cycle after push; 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = valid ? mem_q[rd_ptr_q] : '0;
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;

  // Pointer and occupancy update; pointers wrap at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 byte parser, typematic filter
// and key event queue.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int FILTER_REPEAT = 1,
  parameter int MAKE_ONLY     = 0,
  parameter int PAUSE_SKIP    = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ps2_key_pressed,
  input  logic [7:0]                 ps2_out,
  input  logic                       rd_en,
  input  logic                       clear,
  output logic                       evt_valid,
  output logic [EVT_W-1:0]           evt_data,
  output logic [$clog2(DEPTH+1)-1:0] evt_count,
  output logic                       full,
  output logic                       overflow
);

  localparam int SW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP+1);

  ps2_state_e     state_q, state_d;
  logic [SW-1:0]  skip_q, skip_d;
  logic [511:0]   held_q, held_d;
  logic           overflow_q, overflow_d;
  logic           emit, e_ext, e_brk;
  logic           push;
  logic           dropped;
  logic           reset_all;
  logic [8:0]     idx;
  logic [EVT_W-1:0] wdata;

  assign reset_all = reset || clear;
  assign idx       = {e_ext, ps2_out};
  assign overflow  = overflow_q;

  always_comb begin
    wdata = '0;
    wdata[EVT_EXT_BIT] = e_ext;
    wdata[EVT_BRK_BIT] = e_brk;
    wdata[EVT_CODE_LO +: 8] = ps2_out;
  end

  // Parser: advance on each strobed byte, flag emitted events.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    e_ext   = 1'b0;
    e_brk   = 1'b0;
    if (ps2_key_pressed) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_out == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_out == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (ps2_out == PS2_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = SW'(PAUSE_SKIP);
          end else if (!is_discard(ps2_out)) begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2_out == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (ps2_out != PS2_EXT) begin
            emit    = 1'b1;
            e_ext   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit    = 1'b1;
          e_brk   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          emit    = 1'b1;
          e_ext   = 1'b1;
          e_brk   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_q <= SW'(1)) begin
            skip_d  = '0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - SW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Held-key map and repeat filter; decides what reaches the queue.
  always_comb begin
    held_d = held_q;
    push   = 1'b0;
    if (emit) begin
      if (!e_brk) begin
        if (!((FILTER_REPEAT != 0) && held_q[idx])) begin
          held_d[idx] = 1'b1;
          push        = 1'b1;
        end
      end else begin
        held_d[idx] = 1'b0;
        push        = (MAKE_ONLY == 0);
      end
    end
    overflow_d = overflow_q || dropped;
  end

  // Parser, held map and sticky overflow registers.
  always_ff @(posedge clock) begin
    if (reset_all) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      held_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset_all),
    .push    (push),
    .pop     (rd_en),
    .wdata   (wdata),
    .rdata   (evt_data),
    .valid   (evt_valid),
    .count   (evt_count),
    .full    (full),
    .dropped (dropped)
  );

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue.
// Table vectors plus overflow/reset/make-only sequences.
module tb_ps2_key_event_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_out = 8'h00;
  logic       rd_en = 1'b0;
  logic       clear = 1'b0;

  logic       v1, f1, o1;
  logic [9:0] d1;
  logic [4:0] c1;
  logic       v2, f2, o2;
  logic [9:0] d2;
  logic [4:0] c2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ps2_key_event_queue #(
    .DEPTH(16), .FILTER_REPEAT(1), .MAKE_ONLY(0), .PAUSE_SKIP(7)
  ) dut (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
    .ps2_out(ps2_out), .rd_en(rd_en), .clear(clear),
    .evt_valid(v1), .evt_data(d1), .evt_count(c1),
    .full(f1), .overflow(o1)
  );

  ps2_key_event_queue #(
    .DEPTH(16), .FILTER_REPEAT(1), .MAKE_ONLY(1), .PAUSE_SKIP(7)
  ) dut_mo (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
    .ps2_out(ps2_out), .rd_en(rd_en), .clear(clear),
    .evt_valid(v2), .evt_data(d2), .evt_count(c2),
    .full(f2), .overflow(o2)
  );

  typedef struct {
    logic       s;
    logic [7:0] b;
    logic       rd;
    logic       clr;
    logic       ev;
    logic [9:0] ed;
    logic [4:0] ec;
    logic       ef;
    logic       eo;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic s, input logic [7:0] b, input logic rd,
                     input logic clr, input logic ev, input logic [9:0] ed,
                     input logic [4:0] ec);
    vec_t v;
    v.s = s; v.b = b; v.rd = rd; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ec = ec; v.ef = 1'b0; v.eo = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [7:0] b,
                      input logic rd, input logic clr, input logic rst);
    ps2_key_pressed = s;
    ps2_out = b;
    rd_en = rd;
    clear = clr;
    reset = rst;
    @(posedge clock);
    #1;
    ps2_key_pressed = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
    reset = 1'b0;
  endtask

  task automatic chk1(input string n, input logic ev, input logic [9:0] ed,
                      input logic [4:0] ec, input logic ef, input logic eo);
    chk({n, ".valid"}, 32'(v1), 32'(ev));
    chk({n, ".data"}, 32'(d1), 32'(ed));
    chk({n, ".count"}, 32'(c1), 32'(ec));
    chk({n, ".full"}, 32'(f1), 32'(ef));
    chk({n, ".ovf"}, 32'(o1), 32'(eo));
  endtask

  task automatic chk2(input string n, input logic ev, input logic [9:0] ed,
                      input logic [4:0] ec);
    chk({n, ".valid"}, 32'(v2), 32'(ev));
    chk({n, ".data"}, 32'(d2), 32'(ed));
    chk({n, ".count"}, 32'(c2), 32'(ec));
    chk({n, ".full"}, 32'(f2), 32'd0);
    chk({n, ".ovf"}, 32'(o2), 32'd0);
  endtask

  initial begin
    // make / break pairs, popped after each
    add(1, 8'h1C, 0, 0, 1, 10'h01C, 1);
    add(0, 8'h00, 1, 0, 0, 10'h000, 0);
    add(1, 8'hF0, 0, 0, 0, 10'h000, 0);
    add(1, 8'h1C, 0, 0, 1, 10'h11C, 1);
    add(0, 8'h00, 1, 0, 0, 10'h000, 0);
    // extended make and break
    add(1, 8'hE0, 0, 0, 0, 10'h000, 0);
    add(1, 8'h75, 0, 0, 1, 10'h275, 1);
    add(1, 8'hE0, 1, 0, 0, 10'h000, 0);
    add(1, 8'hF0, 0, 0, 0, 10'h000, 0);
    add(1, 8'h75, 0, 0, 1, 10'h375, 1);
    add(0, 8'h00, 1, 0, 0, 10'h000, 0);
    // typematic repeats filtered
    add(1, 8'h1C, 0, 0, 1, 10'h01C, 1);
    add(1, 8'h1C, 0, 0, 1, 10'h01C, 1);
    add(1, 8'h1C, 0, 0, 1, 10'h01C, 1);
    add(1, 8'hF0, 0, 0, 1, 10'h01C, 1);
    add(1, 8'h1C, 0, 0, 1, 10'h01C, 2);
    add(0, 8'h00, 1, 0, 1, 10'h11C, 1);
    add(0, 8'h00, 1, 0, 0, 10'h000, 0);
    // pause sequence skipped, then 29
    add(1, 8'hE1, 0, 0, 0, 10'h000, 0);
    add(1, 8'h14, 0, 0, 0, 10'h000, 0);
    add(1, 8'h77, 0, 0, 0, 10'h000, 0);
    add(1, 8'hE1, 0, 0, 0, 10'h000, 0);
    add(1, 8'hF0, 0, 0, 0, 10'h000, 0);
    add(1, 8'h14, 0, 0, 0, 10'h000, 0);
    add(1, 8'hF0, 0, 0, 0, 10'h000, 0);
    add(1, 8'h77, 0, 0, 0, 10'h000, 0);
    add(1, 8'h29, 0, 0, 1, 10'h029, 1);
    add(0, 8'h00, 1, 0, 0, 10'h000, 0);
    // discard byte, pop on empty, clear beats strobe
    add(1, 8'hAA, 0, 0, 0, 10'h000, 0);
    add(0, 8'h00, 1, 0, 0, 10'h000, 0);
    add(1, 8'h55, 0, 1, 0, 10'h000, 0);
    add(1, 8'h55, 0, 0, 1, 10'h055, 1);
    add(0, 8'h00, 1, 0, 0, 10'h000, 0);

    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk1("reset", 0, 10'h000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].b, tbl[i].rd, tbl[i].clr, 1'b0);
      chk1($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec,
           tbl[i].ef, tbl[i].eo);
    end

    // fill: 16 distinct makes, then one more overflows
    for (int i = 0; i < 16; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
    chk1("fill16", 1, 10'h030, 16, 1, 0);
    step(1, 8'h40, 0, 0, 0);
    chk1("ovf17", 1, 10'h030, 16, 1, 1);
    step(1, 8'h41, 1, 0, 0);
    chk1("pushpop_full", 1, 10'h031, 16, 1, 1);

    // partial extended-break prefix discarded by reset
    step(1, 8'hE0, 0, 0, 0);
    step(1, 8'hF0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    chk1("rst_mid", 0, 10'h000, 0, 0, 0);
    step(1, 8'h74, 0, 0, 0);
    chk1("after_rst", 1, 10'h074, 1, 0, 0);
    step(1, 8'h30, 0, 0, 0);
    chk1("held_clr", 1, 10'h074, 2, 0, 0);

    // make-only instance
    step(0, 8'h00, 0, 1, 0);
    chk1("clear1", 0, 10'h000, 0, 0, 0);
    chk2("mo_clear", 0, 10'h000, 0);
    step(1, 8'h1C, 0, 0, 0);
    step(1, 8'hF0, 0, 0, 0);
    step(1, 8'h1C, 0, 0, 0);
    chk2("mo_brk", 1, 10'h01C, 1);
    step(1, 8'h1C, 0, 0, 0);
    chk2("mo_two", 1, 10'h01C, 2);
    step(0, 8'h00, 1, 0, 0);
    chk2("mo_pop", 1, 10'h01C, 1);
    step(0, 8'h00, 0, 1, 0);
    chk2("mo_clear2", 0, 10'h000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
